// File: rtl/anpc_gate_monitor_pkg.sv
// Shared constants and helpers for the 3L-ANPC gate read-back monitor.
// Holds the level encoding, fault bit positions, switch indices into the
// 6-bit gate vector, and the pure decode / shoot-through functions.
package anpc_gate_monitor_pkg;

  // Width of the dead-time threshold and the per-pair elapsed counters.
  localparam int TDELAY_WIDTH = 8;

  // Output level encoding, identical to the gate FSM's v_lev encoding.
  localparam logic [1:0] LEV_P = 2'b01;
  localparam logic [1:0] LEV_Z = 2'b00;
  localparam logic [1:0] LEV_N = 2'b10;

  // Bit positions inside fault_flags.
  localparam int FLT_SHOOT  = 0;
  localparam int FLT_DT_TOP = 1;  // pair S1/S5
  localparam int FLT_DT_BOT = 2;  // pair S4/S6
  localparam int FLT_DT_INN = 3;  // pair S2/S3

  // Switch positions inside the 6-bit gate vector.
  localparam int S1 = 0;  // outer-top
  localparam int S2 = 1;  // inner-top
  localparam int S3 = 2;  // inner-bottom
  localparam int S4 = 3;  // outer-bottom
  localparam int S5 = 4;  // clamp-top
  localparam int S6 = 5;  // clamp-bottom

  // Result of decoding one gate vector.
  typedef struct packed {
    logic       valid;
    logic [1:0] lev;
  } lev_dec_t;

  // Map a gate vector to a steady output level. Switches not named in a
  // pattern are don't-care; anything else is transitional or all-off.
  function automatic lev_dec_t decode_level(input logic [5:0] s);
    lev_dec_t r;
    // NOTE: every path of combinational code assigns a default first so no
    // latch is inferred when a branch is skipped.
    r.valid = 1'b0;
    r.lev   = LEV_Z;
    if (s[S1] && s[S2] && !s[S3] && !s[S4] && !s[S5]) begin
      r.valid = 1'b1;
      r.lev   = LEV_P;
    end else if (s[S3] && s[S4] && !s[S1] && !s[S2] && !s[S6]) begin
      r.valid = 1'b1;
      r.lev   = LEV_N;
    end else if (!s[S1] && !s[S4] &&
                 ((s[S2] && s[S5]) || (s[S3] && s[S6]))) begin
      r.valid = 1'b1;
      r.lev   = LEV_Z;
    end
    return r;
  endfunction

  // Any combination that shorts half of the DC link through the leg.
  function automatic logic shoot_through(input logic [5:0] s);
    return (s[S1] & s[S5]) | (s[S4] & s[S6]) |
           (s[S2] & s[S3] & (s[S1] | s[S4]));
  endfunction

endpackage

// File: rtl/anpc_dt_pair_check.sv
// Dead-time checker for one complementary switch pair.
// Tracks cycles since the most recent turn-off of either member and flags a
// turn-on that arrives sooner than t_dead_min cycles after it.
module anpc_dt_pair_check
  import anpc_gate_monitor_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a,
  input  logic                    a_prev,
  input  logic                    b,
  input  logic                    b_prev,
  input  logic [TDELAY_WIDTH-1:0] t_dead_min,
  output logic                    viol
);

  // All-ones means "no turn-off seen recently"; the counter parks there.
  localparam logic [TDELAY_WIDTH-1:0] CNT_MAX = '1;

  logic                    fall;
  logic                    rise;
  logic [TDELAY_WIDTH-1:0] elapsed;
  logic [TDELAY_WIDTH-1:0] cnt_d;
  logic [TDELAY_WIDTH-1:0] cnt_q;

  // Edge detection on the pair, elapsed time and the violation pulse.
  always_comb begin
    fall    = (a_prev & ~a) | (b_prev & ~b);
    rise    = (~a_prev & a) | (~b_prev & b);
    // A turn-off and turn-on in the same cycle means zero separation.
    elapsed = fall ? '0 : cnt_q;
    // A zero threshold disables the check altogether.
    viol    = rise && (t_dead_min != '0) && (elapsed < t_dead_min);
  end

  // Saturating elapsed-time counter, restarted at 1 by each turn-off.
  always_comb begin
    if (fall) begin
      cnt_d = TDELAY_WIDTH'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register; reset presets it to "no recent turn-off".
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its next value from the same pre-edge snapshot.
    if (rst) begin
      cnt_q <= CNT_MAX;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/anpc_gate_monitor.sv
// Read-back monitor for the 3L-ANPC leg gate signals.
// Decodes the applied level, counts level commutations, and latches sticky
// shoot-through and dead-time faults. Purely observational: S_in is never
// altered, and fault is a status output only.
module anpc_gate_monitor
  import anpc_gate_monitor_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              S_in,
  input  logic [TDELAY_WIDTH-1:0] t_dead_min,
  input  logic                    clear_fault,
  output logic [1:0]              lev_meas,
  output logic                    lev_valid,
  output logic [3:0]              fault_flags,
  output logic                    fault,
  output logic [CNT_W-1:0]        comm_count
);

  lev_dec_t         dec;
  logic [5:0]       s_prev_d,      s_prev_q;
  logic [1:0]       lev_meas_d,    lev_meas_q;
  logic             lev_valid_d,   lev_valid_q;
  logic             seen_valid_d,  seen_valid_q;
  logic [CNT_W-1:0] comm_count_d,  comm_count_q;
  logic [3:0]       fault_flags_d, fault_flags_q;
  logic [3:0]       new_fault;
  logic             viol_top;
  logic             viol_bot;
  logic             viol_inn;

  // Dead-time checker for the outer-top / clamp-top pair.
  anpc_dt_pair_check u_dt_top (
    .clk        (clk),
    .rst        (rst),
    .a          (S_in[S1]),
    .a_prev     (s_prev_q[S1]),
    .b          (S_in[S5]),
    .b_prev     (s_prev_q[S5]),
    .t_dead_min (t_dead_min),
    .viol       (viol_top)
  );

  // Dead-time checker for the outer-bottom / clamp-bottom pair.
  anpc_dt_pair_check u_dt_bot (
    .clk        (clk),
    .rst        (rst),
    .a          (S_in[S4]),
    .a_prev     (s_prev_q[S4]),
    .b          (S_in[S6]),
    .b_prev     (s_prev_q[S6]),
    .t_dead_min (t_dead_min),
    .viol       (viol_bot)
  );

  // Dead-time checker for the inner pair.
  anpc_dt_pair_check u_dt_inn (
    .clk        (clk),
    .rst        (rst),
    .a          (S_in[S2]),
    .a_prev     (s_prev_q[S2]),
    .b          (S_in[S3]),
    .b_prev     (s_prev_q[S3]),
    .t_dead_min (t_dead_min),
    .viol       (viol_inn)
  );

  // Level decode; lev_meas holds the last valid level through transitions.
  always_comb begin
    dec          = decode_level(S_in);
    s_prev_d     = S_in;
    lev_valid_d  = dec.valid;
    lev_meas_d   = lev_meas_q;
    seen_valid_d = seen_valid_q;
    if (dec.valid) begin
      lev_meas_d   = dec.lev;
      seen_valid_d = 1'b1;
    end
  end

  // Commutation count: a new valid level that differs from the last valid
  // one. Invalid cycles in between are ignored, so P->off->N counts once.
  // lev_meas resets to the zero level, so the first valid level after reset
  // must count even when it is zero; seen_valid tracks that.
  always_comb begin
    comm_count_d = comm_count_q;
    if (dec.valid && (!seen_valid_q || (dec.lev != lev_meas_q))) begin
      comm_count_d = comm_count_q + 1'b1;
    end
  end

  // Sticky fault latch; a fault detected this cycle beats clear_fault.
  always_comb begin
    new_fault             = '0;
    new_fault[FLT_SHOOT]  = shoot_through(S_in);
    new_fault[FLT_DT_TOP] = viol_top;
    new_fault[FLT_DT_BOT] = viol_bot;
    new_fault[FLT_DT_INN] = viol_inn;
    fault_flags_d         = new_fault | (fault_flags_q & {4{~clear_fault}});
  end

  // State registers; reset discards all history.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q      <= '0;
      lev_meas_q    <= LEV_Z;
      lev_valid_q   <= 1'b0;
      seen_valid_q  <= 1'b0;
      comm_count_q  <= '0;
      fault_flags_q <= '0;
    end else begin
      s_prev_q      <= s_prev_d;
      lev_meas_q    <= lev_meas_d;
      lev_valid_q   <= lev_valid_d;
      seen_valid_q  <= seen_valid_d;
      comm_count_q  <= comm_count_d;
      fault_flags_q <= fault_flags_d;
    end
  end

  assign lev_meas    = lev_meas_q;
  assign lev_valid   = lev_valid_q;
  assign fault_flags = fault_flags_q;
  assign fault       = |fault_flags_q;
  assign comm_count  = comm_count_q;

endmodule

// File: tb/tb_anpc_gate_monitor.sv
// Self-checking bench for anpc_gate_monitor: directed scenarios followed by
// randomized gate patterns, all compared against a cycle-level reference
// model that works from switch states, cycle stamps and a last-level memory.
module tb_anpc_gate_monitor;
  import anpc_gate_monitor_pkg::*;

  localparam int CNT_W = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [5:0]              S_in;
  logic [TDELAY_WIDTH-1:0] t_dead_min;
  logic                    clear_fault;
  logic [1:0]              lev_meas;
  logic                    lev_valid;
  logic [3:0]              fault_flags;
  logic                    fault;
  logic [CNT_W-1:0]        comm_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int         m_last_lev;     // -1: no valid level since reset
  logic [1:0] m_lev;
  logic       m_valid;
  logic [3:0] m_flags;
  int         m_comm;
  logic [5:0] m_prev;
  int         m_last_fall[3]; // cycle stamp of each pair's latest turn-off
  int         m_cyc;

  anpc_gate_monitor #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .S_in        (S_in),
    .t_dead_min  (t_dead_min),
    .clear_fault (clear_fault),
    .lev_meas    (lev_meas),
    .lev_valid   (lev_valid),
    .fault_flags (fault_flags),
    .fault       (fault),
    .comm_count  (comm_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict the outputs that follow one clock edge with these inputs.
  task automatic model_step(input logic r, input logic [5:0] s,
                            input int t, input logic clr);
    int   pa[3] = '{0, 3, 1};  // S1, S4, S2
    int   pb[3] = '{4, 5, 2};  // S5, S6, S3
    int   lev;
    logic [3:0] nf;
    if (r) begin
      m_lev = 2'b00; m_valid = 1'b0; m_flags = 4'b0; m_comm = 0;
      m_prev = 6'b0; m_last_lev = -1; m_cyc = 0;
      for (int k = 0; k < 3; k++) m_last_fall[k] = -1000000;
      return;
    end
    lev = -1;
    if (s[0] && s[1] && !s[2] && !s[3] && !s[4])      lev = 1;
    else if (s[2] && s[3] && !s[0] && !s[1] && !s[5]) lev = 2;
    else if (!s[0] && !s[3] && ((s[1] && s[4]) || (s[2] && s[5]))) lev = 0;
    m_valid = (lev >= 0);
    if (m_valid) begin
      m_lev = 2'(lev);
      if (lev != m_last_lev) m_comm = (m_comm + 1) % 65536;
      m_last_lev = lev;
    end
    nf    = 4'b0;
    nf[0] = (s[0] && s[4]) || (s[3] && s[5]) || (s[1] && s[2] && (s[0] || s[3]));
    for (int k = 0; k < 3; k++) begin
      bit fell, rose;
      int e;
      fell = (m_prev[pa[k]] && !s[pa[k]]) || (m_prev[pb[k]] && !s[pb[k]]);
      rose = (!m_prev[pa[k]] && s[pa[k]]) || (!m_prev[pb[k]] && s[pb[k]]);
      if (fell) e = 0;
      else e = (m_cyc - m_last_fall[k] > 255) ? 255 : m_cyc - m_last_fall[k];
      nf[k+1] = rose && (t != 0) && (e < t);
      if (fell) m_last_fall[k] = m_cyc;
    end
    m_flags = nf | (clr ? 4'b0 : m_flags);
    m_prev  = s;
    m_cyc++;
  endtask

  task automatic compare_all();
    check("lev_meas",    32'(lev_meas),    32'(m_lev));
    check("lev_valid",   32'(lev_valid),   32'(m_valid));
    check("fault_flags", 32'(fault_flags), 32'(m_flags));
    check("fault",       32'(fault),       32'(|m_flags));
    check("comm_count",  32'(comm_count),  32'(m_comm));
  endtask

  // Apply one cycle of inputs, then compare on the following falling edge.
  task automatic step(input logic r, input logic [5:0] s, input int t,
                      input logic clr);
    rst = r; S_in = s; t_dead_min = TDELAY_WIDTH'(t); clear_fault = clr;
    model_step(r, s, t, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input logic [5:0] s);
    for (int i = 0; i < 3; i++) step(1'b1, s, 0, 1'b0);
  endtask

  initial begin
    logic [5:0] pats[10] = '{6'b000011, 6'b100011, 6'b010010, 6'b100100,
                            6'b110110, 6'b001100, 6'b011100, 6'b000000,
                            6'b000010, 6'b000100};

    // Reset held with every gate on: all outputs stay cleared.
    do_reset(6'b111111);
    check("rst_lev_meas", 32'(lev_meas), 0);
    check("rst_fault",    32'(fault),    0);
    check("rst_comm",     32'(comm_count), 0);

    // Release straight into P: level appears one cycle later, one commutation.
    step(1'b0, 6'b000011, 0, 1'b0);
    check("p_lev",   32'(lev_meas),   32'(LEV_P));
    check("p_valid", 32'(lev_valid),  1);
    check("p_comm",  32'(comm_count), 1);
    step(1'b0, 6'b000011, 0, 1'b0);
    check("p_hold_comm", 32'(comm_count), 1);
    check("p_no_fault",  32'(fault),      0);

    // S1 off, S5 on two cycles later with threshold 3: top-pair violation.
    do_reset(6'b000000);
    step(1'b0, 6'b100011, 3, 1'b0);
    step(1'b0, 6'b100010, 3, 1'b0);
    step(1'b0, 6'b100010, 3, 1'b0);
    step(1'b0, 6'b110010, 3, 1'b0);
    check("dt_top_flags", 32'(fault_flags), 32'h2);
    check("dt_top_fault", 32'(fault),       1);
    for (int i = 0; i < 3; i++) step(1'b0, 6'b110010, 3, 1'b0);
    check("dt_top_sticky", 32'(fault_flags), 32'h2);

    // Same sequence with the check disabled.
    do_reset(6'b000000);
    step(1'b0, 6'b100011, 0, 1'b0);
    step(1'b0, 6'b100010, 0, 1'b0);
    step(1'b0, 6'b100010, 0, 1'b0);
    step(1'b0, 6'b110010, 0, 1'b0);
    check("dt_off_flags", 32'(fault_flags), 0);

    // Shoot-through, clear while clean, clear while persisting.
    do_reset(6'b000000);
    step(1'b0, 6'b010001, 0, 1'b0);
    step(1'b0, 6'b000000, 0, 1'b0);
    check("st_set", 32'(fault_flags), 32'h1);
    step(1'b0, 6'b000000, 0, 1'b1);
    check("st_clear", 32'(fault_flags), 0);
    step(1'b0, 6'b010001, 0, 1'b0);
    step(1'b0, 6'b010001, 0, 1'b1);
    check("st_clear_loses", 32'(fault_flags), 32'h1);

    // P -> all-off for 5 cycles -> N, threshold 3: one commutation per level.
    do_reset(6'b000000);
    step(1'b0, 6'b000011, 3, 1'b0);
    step(1'b0, 6'b000011, 3, 1'b0);
    check("pon_valid", 32'(lev_valid), 1);
    for (int i = 0; i < 5; i++) step(1'b0, 6'b000000, 3, 1'b0);
    check("pon_off_valid", 32'(lev_valid), 0);
    check("pon_off_lev",   32'(lev_meas),  32'(LEV_P));
    step(1'b0, 6'b001100, 3, 1'b0);
    step(1'b0, 6'b001100, 3, 1'b0);
    check("pon_n_lev",  32'(lev_meas),    32'(LEV_N));
    check("pon_comm",   32'(comm_count),  2);
    check("pon_nofault", 32'(fault_flags), 0);

    // Randomized gate patterns held for random lengths.
    for (int n = 0; n < 600; n++) begin
      logic [5:0] s;
      int         idx, hold, t;
      idx  = $urandom_range(0, 10);
      s    = (idx == 10) ? 6'($urandom) : pats[idx];
      hold = $urandom_range(1, 6);
      t    = $urandom_range(0, 6);
      for (int h = 0; h < hold; h++) begin
        logic r;
        r = ($urandom_range(0, 299) == 0);
        step(r, s, t, ($urandom_range(0, 7) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
